vga_timing_ctrl: RTL
====================

# vga_timing_ctrl

Hardware VGA timing controller that sequences the 12-bit RGB, HSYNC and VSYNC pads on the Arty A7 demo system, taking them off software-driven GPO bits. It runs nested horizontal and vertical porch/sync state machines on a pixel-rate strobe. It pulls one pixel per active position from an upstream valid/ready stream, such as a framebuffer reader. It flags stream underflow to software.

## Interface
- HActive, 640, visible pixels per line
- HFront, 16, horizontal front porch (pixels)
- HSync, 96, horizontal sync width (pixels)
- HBack, 48, horizontal back porch (pixels)
- VActive, 480, visible lines per frame
- VFront, 10, vertical front porch (lines)
- VSync, 2, vertical sync width (lines)
- VBack, 33, vertical back porch (lines)
- SyncPol, 1'b0, asserted level of hsync_o/vsync_o (0 = active-low)
- clk_sys_i  input  1  system clock
- rst_sys_i  input  1  reset; **synchronous, active-high**
- en_i  input  1  run enable; low holds the controller idle
- pix_en_i  input  1  pixel-rate strobe: one clk_sys_i cycle per pixel, e.g. every 2nd cycle at 50 MHz
- pix_valid_i  input  1  upstream pixel available
- pix_data_i  input  12  pixel {R[3:0],G[3:0],B[3:0]}
- pix_ready_o  output  1  pixel consumed this cycle
- rgb_o  output  12  registered pixel to pads
- hsync_o  output  1  registered horizontal sync
- vsync_o  output  1  registered vertical sync
- frame_start_o  output  1  one-cycle pulse when pixel (0,0) is consumed or blanked
- underflow_o  output  1  sticky: an active pixel found pix_valid_i low

## Operation
- Horizontal FSM: H_ACTIVE → H_FRONT → H_SYNC → H_BACK → H_ACTIVE.
  - The FSM advances only on pix_en_i.
  - An 11-bit in-state counter counts 0..N-1 and clears on each transition.
- Vertical FSM: V_ACTIVE → V_FRONT → V_SYNC → V_BACK → V_ACTIVE.
  - Same structure as the horizontal FSM.
  - Its counter advances only on pix_en_i in the last H_BACK pixel.
- Active position: H_ACTIVE && V_ACTIVE.
- pix_ready_o = en_i && pix_en_i && active position (combinational).
- A transfer occurs when pix_ready_o && pix_valid_i.
  - On a transfer, rgb_o takes pix_data_i on the next edge.
- Underflow: active position with pix_en_i but pix_valid_i low.
  - rgb_o takes 12'h000.
  - underflow_o sets.
  - The timing counters never stall.
- Blanking: rgb_o takes 12'h000 on each pix_en_i outside the active position.
- Syncs: hsync_o = SyncPol while in H_SYNC, else ~SyncPol. vsync_o behaves the same for V_SYNC.
  - Both are registered on pix_en_i, aligned with rgb_o.
- Idle (en_i low, or rst_sys_i):
  - FSMs go to H_ACTIVE/V_ACTIVE with counters at 0.
  - rgb_o = 0, hsync_o = vsync_o = ~SyncPol, frame_start_o = 0, pix_ready_o = 0.
  - underflow_o clears.
- en_i rising: the first pix_en_i after it is pixel (0,0).
- en_i falling mid-frame: idle on the next edge, with no frame completion.
- rst_sys_i has priority over en_i. The reset values equal the idle values.

## Timing
- Line period: HActive+HFront+HSync+HBack pix_en_i strobes.
- Frame period: line period × (VActive+VFront+VSync+VBack).
- Pad latency:
  - rgb_o/hsync_o/vsync_o change one clk_sys_i edge after the pix_en_i cycle that selects them.
  - They hold until the next pix_en_i.
- frame_start_o is high for exactly one clk_sys_i cycle, the cycle after the pix_en_i of pixel (0,0).
- pix_valid_i/pix_data_i are sampled only when pix_ready_o is high. pix_ready_o does not depend on pix_valid_i.
- pix_en_i low: all state and outputs hold. frame_start_o returns to 0.

## Configuration
- Macro: `VGA_TIMING_CTRL_TEST_PATTERN_EN`.
- Defined:
  - Adds input test_pat_i (1 bit).
  - When test_pat_i is high, active pixels are 8 vertical colour bars. The bar index is the horizontal counter × 8 / HActive. Colours run from 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F to 12'h000.
  - pix_ready_o stays 0 and underflow_o never sets.
- Undefined: no test_pat_i port; the stream path only.

## Structure
- Package vga_timing_pkg holds:
  - the FSM state enum (ACTIVE, FRONT, SYNC, BACK), shared by both axes;
  - the 11-bit counter width constant;
  - the colour-bar constant array.
- One sub-module, vga_axis_fsm: state plus counter, with step and period inputs and a wrap output.
  - Instantiated twice.
  - The horizontal wrap gates the vertical step.

## Test plan
- Reduced params for all tests: HActive=4, HFront=1, HSync=2, HBack=1, VActive=3, VFront=1, VSync=1, VBack=1.
  - Line period is 8 pix_en_i strobes; frame period is 48.
- Reset check: rst_sys_i high for 3 cycles, en_i=1 → rgb_o=0, hsync_o=vsync_o=1, pix_ready_o=0, underflow_o=0.
- Stream frame: pix_en_i every 2nd cycle, pix_valid_i=1 with an incrementing pattern from 12'h001 →
  - 12 transfers per frame, values 001..00C on rgb_o in order;
  - hsync_o low for 2 strobes per line;
  - vsync_o low for 8 strobes;
  - frame_start_o pulses every 96 clk_sys_i cycles.
- Underflow: pix_valid_i dropped for pixel (2,1) → rgb_o=000 for that pixel, underflow_o=1 and held, and later pixels still align to the counters.
- Mid-frame disable: en_i low at line 1 pixel 3, re-raised 5 cycles later → idle values on the next edge, underflow_o cleared, and the next pix_en_i is pixel (0,0) with a frame_start_o pulse.
- Gated strobe: pix_en_i held low for 20 cycles mid-line → all outputs and pix_ready_o static, then the sequence continues uninterrupted.
- With `VGA_TIMING_CTRL_TEST_PATTERN_EN` and test_pat_i=1, HActive=8 → active pixels FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000 on every line, and pix_ready_o stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared types and constants for the VGA timing controller
//
// Holds the per-axis FSM state encoding (used by both the horizontal and the
// vertical axis), the in-state counter width and the colour-bar table used
// by the optional test pattern (VGA_TIMING_CTRL_TEST_PATTERN_EN).

package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

  localparam int CNT_W = 11;

  // Entry 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][11:0] BAR_COLOURS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

endpackage

// File: rtl/vga_axis_fsm.sv
// rtl/vga_axis_fsm.sv - one timing axis: ACTIVE/FRONT/SYNC/BACK state plus in-state counter
//
// Ports:
//   clk        clock
//   clear      synchronous clear to ACTIVE with counter 0 (reset or idle)
//   step       advance one position
//   active_len, front_len, sync_len, back_len  period of each state
//   state      current state (axis_state_t encoding)
//   cnt        position within the current state, 0..N-1
//   wrap       high on the step that leaves the last BACK position

module vga_axis_fsm
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             step,
  input  logic [CNT_W-1:0] active_len,
  input  logic [CNT_W-1:0] front_len,
  input  logic [CNT_W-1:0] sync_len,
  input  logic [CNT_W-1:0] back_len,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  axis_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    case (state_q)
      ACTIVE:  len = active_len;
      FRONT:   len = front_len;
      SYNC:    len = sync_len;
      BACK:    len = back_len;
      default: len = active_len;
    endcase
    if (step) begin
      if (cnt_q == len - CNT_W'(1)) begin
        cnt_d = '0;
        case (state_q)
          ACTIVE:  state_d = FRONT;
          FRONT:   state_d = SYNC;
          SYNC:    state_d = BACK;
          BACK:    state_d = ACTIVE;
          default: state_d = ACTIVE;
        endcase
        wrap = (state_q == BACK);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA timing controller driving RGB/HSYNC/VSYNC pads from a pixel stream
//
// Optional feature macro: VGA_TIMING_CTRL_TEST_PATTERN_EN (adds test_pat_i, colour bars).
//
// Ports:
//   clk_sys_i      system clock
//   rst_sys_i      synchronous active-high reset
//   en_i           run enable; low holds the controller idle
//   test_pat_i     (macro only) replace the stream with 8 vertical colour bars
//   pix_en_i       pixel-rate strobe, one clock per pixel
//   pix_valid_i    upstream pixel available
//   pix_data_i     upstream pixel {R,G,B} 4 bits each
//   pix_ready_o    pixel consumed this cycle (combinational)
//   rgb_o          registered pixel to pads
//   hsync_o        registered horizontal sync
//   vsync_o        registered vertical sync
//   frame_start_o  one-cycle pulse after pixel (0,0)
//   underflow_o    sticky: an active pixel found no valid data

module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   HActive = 640,
  parameter int   HFront  = 16,
  parameter int   HSync   = 96,
  parameter int   HBack   = 48,
  parameter int   VActive = 480,
  parameter int   VFront  = 10,
  parameter int   VSync   = 2,
  parameter int   VBack   = 33,
  parameter logic SyncPol = 1'b0
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic        en_i,
`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
  input  logic        test_pat_i,
`endif
  input  logic        pix_en_i,
  input  logic        pix_valid_i,
  input  logic [11:0] pix_data_i,
  output logic        pix_ready_o,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o,
  output logic        underflow_o
);

  logic             idle;
  logic [1:0]       h_state, v_state;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             active;
  logic             stream_act;
  logic [11:0]      pix_rgb;
  logic             underflow_now;

  // Reset and disable share one path so both land on identical idle values.
  assign idle = rst_sys_i || !en_i;

  vga_axis_fsm u_h_axis (
    .clk        (clk_sys_i),
    .clear      (idle),
    .step       (pix_en_i),
    .active_len (CNT_W'(HActive)),
    .front_len  (CNT_W'(HFront)),
    .sync_len   (CNT_W'(HSync)),
    .back_len   (CNT_W'(HBack)),
    .state      (h_state),
    .cnt        (h_cnt),
    .wrap       (h_wrap)
  );

  // Vertical axis steps once per line, on the strobe of the last H_BACK pixel.
  vga_axis_fsm u_v_axis (
    .clk        (clk_sys_i),
    .clear      (idle),
    .step       (h_wrap),
    .active_len (CNT_W'(VActive)),
    .front_len  (CNT_W'(VFront)),
    .sync_len   (CNT_W'(VSync)),
    .back_len   (CNT_W'(VBack)),
    .state      (v_state),
    .cnt        (v_cnt),
    .wrap       (v_wrap)
  );

  // End of frame is implied by the counters returning to (0,0); the pads need no separate marker.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  assign active = (h_state == ACTIVE) && (v_state == ACTIVE);

`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx    = 3'((32'(h_cnt) * 8) / HActive);
  assign stream_act = active && !test_pat_i;
`else
  assign stream_act = active;
`endif

  assign pix_ready_o = !idle && pix_en_i && stream_act;

  always_comb begin
    pix_rgb       = 12'h000;
    underflow_now = 1'b0;
    if (active) begin
`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
      if (test_pat_i) begin
        pix_rgb = BAR_COLOURS[bar_idx];
      end else if (pix_valid_i) begin
        pix_rgb = pix_data_i;
      end else begin
        underflow_now = 1'b1;
      end
`else
      if (pix_valid_i) begin
        pix_rgb = pix_data_i;
      end else begin
        underflow_now = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (idle) begin
      rgb_o         <= 12'h000;
      hsync_o       <= ~SyncPol;
      vsync_o       <= ~SyncPol;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      frame_start_o <= pix_en_i && active && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en_i) begin
        rgb_o   <= pix_rgb;
        hsync_o <= (h_state == SYNC) ? SyncPol : ~SyncPol;
        vsync_o <= (v_state == SYNC) ? SyncPol : ~SyncPol;
        if (underflow_now) begin
          underflow_o <= 1'b1;
        end
      end
    end
  end

endmodule
